// File: rtl/uart_frame_filter_if.sv
// Byte-level strobes between the frame filter, the UART rx/tx cores and the
// status counters.
interface uart_frame_filter_if;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic [1:0] mode;
  logic       tx_active;
  logic       tx_done;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [15:0] frame_cnt;
  logic [7:0] err_cnt;
  logic [7:0] ovr_cnt;

  modport master (
    output rx_dv, rx_byte, mode, tx_active, tx_done,
    input  tx_dv, tx_byte, frame_cnt, err_cnt, ovr_cnt
  );

  modport slave (
    input  rx_dv, rx_byte, mode, tx_active, tx_done,
    output tx_dv, tx_byte, frame_cnt, err_cnt, ovr_cnt
  );
endinterface

// File: rtl/uart_frame_filter.sv
// Parses HEADER/channel/sample frames from the UART receiver, filters each
// sample per channel and sends a framed response through the UART transmitter.
module uart_frame_filter #(
  parameter logic [7:0]  HEADER       = 8'hAA,
  parameter int unsigned SAMPLE_BYTES = 1,
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned CLIP_LEVEL   = 200,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input logic               clk_50mhz,
  input logic               reset,
  uart_frame_filter_if.slave bus
);
  localparam int unsigned W       = 8 * SAMPLE_BYTES;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned LAST_TX = SAMPLE_BYTES + 1;

  typedef enum logic [1:0] {WAIT_HDR, GET_CH, GET_DATA, COMMIT} p_state_t;
  typedef enum logic [1:0] {IDLE, WAIT_DONE, SEND} tx_state_t;

  p_state_t        p_state, p_next;
  logic [CH_W-1:0] ch;
  logic [IDX_W-1:0] d_idx;
  logic [W-1:0]    sample;
  logic [TO_W-1:0] to_cnt;
  // Sized for the maximum channel count so the channel register indexes it exactly
  logic [W-1:0]    prev [4];

  logic            pend_valid;
  logic [CH_W-1:0] pend_ch;
  logic [W-1:0]    pend_y;
  logic [15:0]     frame_cnt;
  logic [7:0]      err_cnt;
  logic [7:0]      ovr_cnt;

  tx_state_t       tx_state, tx_next;
  logic [IDX_W-1:0] tx_idx, tx_idx_nx;
  logic            tx_dv_q, tx_dv_nx;
  logic [7:0]      tx_byte_q, tx_byte_nx;

  logic            in_frame_c, timeout_c, bad_ch_c, load_c, drop_c, err_c;
  logic            pend_free_c;
  logic [W-1:0]    y_c, p_c;
  logic [W:0]      sum_c;
  logic [IDX_W-1:0] sel_idx_c;
  logic [7:0]      sel_byte_c;

  // Parser next state and event decode
  always_comb begin
    p_next     = p_state;
    bad_ch_c   = 1'b0;
    load_c     = 1'b0;
    drop_c     = 1'b0;
    in_frame_c = (p_state == GET_CH) || (p_state == GET_DATA);
    timeout_c  = in_frame_c && !bus.rx_dv && (to_cnt == TO_W'(TIMEOUT_CLKS - 1));
    unique case (p_state)
      WAIT_HDR: if (bus.rx_dv && (bus.rx_byte == HEADER)) p_next = GET_CH;
      GET_CH: begin
        if (timeout_c) begin
          p_next = WAIT_HDR;
        end else if (bus.rx_dv) begin
          if (bus.rx_byte < 8'(CHANNELS)) begin
            p_next = GET_DATA;
          end else begin
            bad_ch_c = 1'b1;
            p_next   = WAIT_HDR;
          end
        end
      end
      GET_DATA: begin
        if (timeout_c) p_next = WAIT_HDR;
        else if (bus.rx_dv && (d_idx == IDX_W'(SAMPLE_BYTES - 1))) p_next = COMMIT;
      end
      COMMIT: begin
        p_next = WAIT_HDR;
        load_c = !pend_valid;
        drop_c = pend_valid;
      end
      default: p_next = WAIT_HDR;
    endcase
    err_c = bad_ch_c || timeout_c;
  end

  // Filter datapath; the average keeps the carry so it cannot overflow
  always_comb begin
    p_c   = prev[ch];
    sum_c = {1'b0, sample} + {1'b0, p_c};
    y_c   = sample;
    unique case (bus.mode)
      2'd0:    y_c = sample;
      2'd1:    y_c = (sample > W'(CLIP_LEVEL)) ? W'(CLIP_LEVEL) : sample;
      2'd2:    y_c = sample >> 1;
      default: y_c = sum_c[W:1];
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      p_state    <= WAIT_HDR;
      ch         <= '0;
      d_idx      <= '0;
      sample     <= '0;
      to_cnt     <= '0;
      for (int i = 0; i < 4; i++) prev[i] <= '0;
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_y     <= '0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
      ovr_cnt    <= '0;
    end else begin
      p_state <= p_next;
      if (!in_frame_c || bus.rx_dv || timeout_c) to_cnt <= '0;
      else to_cnt <= to_cnt + TO_W'(1);
      if ((p_state == GET_CH) && bus.rx_dv && !bad_ch_c) begin
        ch    <= bus.rx_byte[CH_W-1:0];
        d_idx <= '0;
      end
      if ((p_state == GET_DATA) && bus.rx_dv) begin
        for (int unsigned b = 0; b < SAMPLE_BYTES; b++)
          if (d_idx == IDX_W'(b)) sample[8*b +: 8] <= bus.rx_byte;
        d_idx <= d_idx + IDX_W'(1);
      end
      if (load_c) begin
        pend_valid <= 1'b1;
        pend_ch    <= ch;
        pend_y     <= y_c;
        prev[ch]   <= sample;
        frame_cnt  <= frame_cnt + 16'd1;
      end else if (pend_free_c) begin
        pend_valid <= 1'b0;
      end
      if (drop_c && (ovr_cnt != 8'hFF)) ovr_cnt <= ovr_cnt + 8'd1;
      if (err_c && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Response byte select: 0 header, 1 channel, then y LSB first
  always_comb begin
    sel_idx_c  = (tx_state == SEND) ? tx_idx : tx_idx + IDX_W'(1);
    sel_byte_c = HEADER;
    if (sel_idx_c == IDX_W'(1)) sel_byte_c = 8'(pend_ch);
    for (int unsigned b = 0; b < SAMPLE_BYTES; b++)
      if (sel_idx_c == IDX_W'(b + 2)) sel_byte_c = pend_y[8*b +: 8];
  end

  // TX next state; a tx_done with the line already free issues the next byte directly
  always_comb begin
    tx_next     = tx_state;
    tx_idx_nx   = tx_idx;
    tx_dv_nx    = 1'b0;
    tx_byte_nx  = tx_byte_q;
    pend_free_c = 1'b0;
    unique case (tx_state)
      IDLE: begin
        if ((pend_valid || load_c) && !bus.tx_active) begin
          tx_dv_nx   = 1'b1;
          tx_byte_nx = HEADER;
          tx_idx_nx  = '0;
          tx_next    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (tx_idx == IDX_W'(LAST_TX)) begin
            pend_free_c = 1'b1;
            tx_next     = IDLE;
          end else begin
            tx_idx_nx = tx_idx + IDX_W'(1);
            if (!bus.tx_active) begin
              tx_dv_nx   = 1'b1;
              tx_byte_nx = sel_byte_c;
            end else begin
              tx_next = SEND;
            end
          end
        end
      end
      SEND: begin
        if (!bus.tx_active) begin
          tx_dv_nx   = 1'b1;
          tx_byte_nx = sel_byte_c;
          tx_next    = WAIT_DONE;
        end
      end
      default: tx_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      tx_state  <= IDLE;
      tx_idx    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      tx_state  <= tx_next;
      tx_idx    <= tx_idx_nx;
      tx_dv_q   <= tx_dv_nx;
      tx_byte_q <= tx_byte_nx;
    end
  end

  assign bus.tx_dv     = tx_dv_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.frame_cnt = frame_cnt;
  assign bus.err_cnt   = err_cnt;
  assign bus.ovr_cnt   = ovr_cnt;
endmodule

// File: tb/tb_uart_frame_filter.sv
// Directed and randomized frames against a per-frame reference model; a
// transmitter model captures response bytes and checks the tx handshake.
module tb_uart_frame_filter;
  localparam int SB        = 2;
  localparam int CH        = 2;
  localparam int CLIP      = 200;
  localparam int TO        = 100;
  localparam int BYTE_CLKS = 3;

  logic clk_50mhz = 1'b0;
  logic reset;
  uart_frame_filter_if bus ();

  uart_frame_filter #(
    .HEADER(8'hAA), .SAMPLE_BYTES(SB), .CHANNELS(CH),
    .CLIP_LEVEL(CLIP), .TIMEOUT_CLKS(TO)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .reset(reset),
    .bus(bus)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] cap_q[$];
  logic hold = 1'b0;
  logic tx_busy;
  logic track;
  int bcnt;
  logic [7:0] held;

  int m_frame = 0;
  int m_err = 0;
  int m_ovr = 0;
  int m_prev[CH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_y(input int m, input int x, input int p);
    case (m)
      0:       return x;
      1:       return (x > CLIP) ? CLIP : x;
      2:       return x / 2;
      default: return (x + p) / 2;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_50mhz);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_byte = b;
    bus.rx_dv   = 1'b1;
    tick(1);
    bus.rx_dv   = 1'b0;
    tick(gap);
  endtask

  // Invalid channels end the frame at the channel byte; last byte has no trailing gap
  task automatic send_frame(input int ch, input int x);
    send_byte(8'hAA, int'($urandom_range(0, 3)));
    if (ch >= CH) begin
      send_byte(8'(ch), 0);
    end else begin
      send_byte(8'(ch), int'($urandom_range(0, 3)));
      send_byte(8'(x & 255), int'($urandom_range(0, 3)));
      send_byte(8'((x >> 8) & 255), 0);
    end
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_frame_cnt"}, 32'(bus.frame_cnt), 32'(m_frame & 16'hFFFF));
    check({tag, "_err_cnt"}, 32'(bus.err_cnt), 32'((m_err > 255) ? 255 : m_err));
    check({tag, "_ovr_cnt"}, 32'(bus.ovr_cnt), 32'((m_ovr > 255) ? 255 : m_ovr));
  endtask

  task automatic expect_resp(input int ch, input int y, input string tag);
    int t = 0;
    while (cap_q.size() < 2 + SB && t < 400) begin
      tick(1);
      t++;
    end
    check({tag, "_count"}, 32'(cap_q.size()), 32'(2 + SB));
    if (cap_q.size() >= 2 + SB) begin
      check({tag, "_hdr"}, 32'(cap_q.pop_front()), 32'hAA);
      check({tag, "_ch"}, 32'(cap_q.pop_front()), 32'(ch));
      check({tag, "_lo"}, 32'(cap_q.pop_front()), 32'(y & 255));
      check({tag, "_hi"}, 32'(cap_q.pop_front()), 32'((y >> 8) & 255));
    end
    tick(8);
    check({tag, "_extra"}, 32'(cap_q.size()), 32'd0);
    cap_q.delete();
  endtask

  task automatic do_frame(input int ch, input int x, input int mode, input string tag);
    int y;
    bus.mode = 2'(mode);
    send_frame(ch, x);
    if (ch < CH) begin
      y = model_y(mode, x, m_prev[ch]);
      m_prev[ch] = x;
      m_frame++;
      expect_resp(ch, y, tag);
    end else begin
      m_err++;
      tick(20);
      check({tag, "_noresp"}, 32'(cap_q.size()), 32'd0);
    end
    check_cnts(tag);
  endtask

  // Transmitter model: busy BYTE_CLKS cycles per byte, tx_done as tx_active drops
  initial begin
    tx_busy = 1'b0;
    track = 1'b0;
    bcnt = 0;
    held = 8'h00;
    bus.tx_active = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk_50mhz);
      #1;
      bus.tx_done = 1'b0;
      if (reset) track = 1'b0;
      if (bus.tx_dv) begin
        check("tx_dv_while_busy", 32'(tx_busy), 32'd0);
        cap_q.push_back(bus.tx_byte);
        held = bus.tx_byte;
        track = 1'b1;
        tx_busy = 1'b1;
        bcnt = BYTE_CLKS;
      end else if (tx_busy) begin
        if (track) check("tx_byte_stable", 32'(bus.tx_byte), 32'(held));
        if (bcnt == 0) begin
          tx_busy = 1'b0;
          bus.tx_done = 1'b1;
        end else begin
          bcnt--;
        end
      end
      bus.tx_active = tx_busy | hold;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int clip_v[4] = '{199, 200, 201, 255};
    int edge_v[5] = '{0, 199, 200, 201, 16'hFFFF};
    int t;
    for (int i = 0; i < CH; i++) m_prev[i] = 0;
    bus.rx_dv = 1'b0;
    bus.rx_byte = 8'h00;
    bus.mode = 2'd0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("rst_tx_dv", 32'(bus.tx_dv), 32'd0);
    check("rst_tx_byte", 32'(bus.tx_byte), 32'd0);
    check_cnts("rst");
    tick(2);

    // Bypass plus first-response latency
    bus.mode = 2'd0;
    send_frame(0, 16'h00FA);
    check("lat_t1_dv", 32'(bus.tx_dv), 32'd0);
    tick(1);
    check("lat_t2_dv", 32'(bus.tx_dv), 32'd1);
    check("lat_t2_hdr", 32'(bus.tx_byte), 32'hAA);
    m_prev[0] = 16'h00FA;
    m_frame++;
    expect_resp(0, 16'h00FA, "bypass");
    check_cnts("bypass");

    foreach (clip_v[i]) do_frame(1, clip_v[i], 1, "clip");
    do_frame(1, 16'h1234, 1, "clip_wide");

    do_frame(0, 16'h0100, 3, "avg_a");
    do_frame(0, 16'h0301, 3, "avg_b");
    do_frame(0, 16'hFFFF, 3, "avg_c");
    do_frame(0, 16'hFFFF, 3, "avg_max");

    do_frame(1, 16'h0001, 2, "att_a");
    do_frame(1, 16'hFFFF, 2, "att_b");

    do_frame(5, 0, 0, "bad_ch");
    do_frame(1, 16'h0055, 0, "after_bad");

    // Stalled frame then a good one
    bus.mode = 2'd0;
    send_byte(8'hAA, 0);
    send_byte(8'h00, 0);
    tick(TO + 10);
    m_err++;
    check_cnts("timeout");
    do_frame(0, 16'h0ABC, 0, "after_to");

    // Two frames while the transmitter is held busy
    hold = 1'b1;
    tick(2);
    bus.mode = 2'd0;
    send_frame(0, 16'h0011);
    tick(3);
    send_frame(1, 16'h0022);
    tick(5);
    m_prev[0] = 16'h0011;
    m_frame++;
    m_ovr++;
    check("ovr_held_quiet", 32'(cap_q.size()), 32'd0);
    check_cnts("ovr_held");
    hold = 1'b0;
    expect_resp(0, 16'h0011, "ovr_first");
    check_cnts("ovr_done");

    // Reset in the middle of a response
    bus.mode = 2'd0;
    send_frame(1, 16'h4321);
    t = 0;
    while (cap_q.size() < 1 && t < 100) begin
      tick(1);
      t++;
    end
    check("rst_mid_started", 32'(cap_q.size() >= 1), 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_tx_dv", 32'(bus.tx_dv), 32'd0);
    m_frame = 0;
    m_err = 0;
    m_ovr = 0;
    for (int i = 0; i < CH; i++) m_prev[i] = 0;
    check_cnts("rst_mid");
    tick(60);
    check("rst_mid_no_tx", 32'(cap_q.size()), 32'd1);
    cap_q.delete();
    do_frame(1, 16'h1234, 3, "avg_after_rst");

    // Randomized frames
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) v = edge_v[$urandom_range(0, 4)];
      else v = int'($urandom & 32'hFFFF);
      do_frame(int'($urandom_range(0, 2)), v, int'($urandom_range(0, 3)), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_frame_filter.md
# uart_frame_filter

Parametrised successor to the single-byte UART echo/clip path. It sits between the UART receiver and transmitter on the Colorlight i9. It parses framed multi-byte, multi-channel samples from the Pico, applies a selectable filter per frame, and returns a complete framed response (header, channel, data). The uart_rx/uart_tx cores stay outside this block; it talks only to their byte-level strobes.

## Interface
- HEADER, 8'hAA, frame start byte
- SAMPLE_BYTES, 1, bytes per sample (1..4); W = 8*SAMPLE_BYTES
- CHANNELS, 2, channel count (1..4); channel byte must be < CHANNELS
- CLIP_LEVEL, 200, clip ceiling, W bits, unsigned
- TIMEOUT_CLKS, 8680, max clocks between consecutive bytes inside a frame (about 20 bit times at 115200 baud)

Ports:
- clk_50mhz  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- rx_dv  in  1  one-cycle strobe, rx_byte valid
- rx_byte  in  8  received byte
- mode  in  2  0 bypass, 1 clip, 2 attenuate (>>1), 3 two-point average
- tx_active  in  1  transmitter busy
- tx_done  in  1  one-cycle strobe, byte finished
- tx_dv  out  1  one-cycle strobe, load tx_byte
- tx_byte  out  8  byte to transmit
- frame_cnt  out  16  accepted frames, wraps
- err_cnt  out  8  dropped frames (bad channel or timeout), saturates at 255
- ovr_cnt  out  8  frames dropped because the pending slot was full, saturates at 255

## Operation
- Frame format, both directions: HEADER, channel byte, then SAMPLE_BYTES data bytes, LSB first.
- Parser FSM states:
  - WAIT_HDR: rx_dv with rx_byte==HEADER goes to GET_CH. Any other byte is ignored without counting an error.
  - GET_CH: if byte < CHANNELS, latch it and go to GET_DATA with byte index 0. Otherwise err_cnt++ and go to WAIT_HDR.
  - GET_DATA: shift each byte into sample[8*idx +: 8]. After the last byte, go to COMMIT.
  - COMMIT: one cycle. Compute the result. If the pending slot is empty, load it and frame_cnt++. If it is full, ovr_cnt++ and drop the frame. Return to WAIT_HDR.
- HEADER value inside GET_CH/GET_DATA is treated as data, not a resync. It is still range-checked when it arrives as the channel byte.
- Timeout: a counter clears on each rx_dv while in GET_CH/GET_DATA. When it reaches TIMEOUT_CLKS with no byte, err_cnt++, the parser goes to WAIT_HDR and the partial frame is discarded.
- Filter. mode is sampled in COMMIT. x is the raw sample; p is prev[ch].
  - Bypass: y = x.
  - Clip: y = (x > CLIP_LEVEL) ? CLIP_LEVEL : x. Equality passes unchanged.
  - Attenuate: y = x >> 1 (floor).
  - Average: y = (x + p) >> 1, computed in W+1 bits so it never overflows.
- prev[ch] <= x (the raw value) on every accepted frame, in all modes. Dropped frames do not update prev. Reset sets all prev to 0.
- TX FSM states:
  - IDLE: when the pending slot is valid and tx_active==0, assert tx_dv with byte 0 (HEADER). Go to WAIT_DONE.
  - WAIT_DONE: on tx_done, advance the byte index. After the last byte (index SAMPLE_BYTES+1), free the pending slot and go to IDLE. Otherwise go to SEND.
  - SEND: when tx_active==0, assert tx_dv with the next byte (channel, then y LSB first). Go to WAIT_DONE.
- The pending slot is freed only when the full response has been sent. The parser runs concurrently with TX.

## Timing
- Reset values: tx_dv=0, tx_byte=0, all counters 0, parser WAIT_HDR, TX IDLE, pending empty, timeout counter 0.
- Latency from the last data byte's rx_dv at cycle T:
  - COMMIT at T+1.
  - Pending valid at T+2.
  - Header tx_dv at T+2 at the earliest, when tx_active==0.
- Inter-byte gap: if tx_done occurs at cycle U, the next tx_dv occurs at U+1 when tx_active==0, otherwise the first cycle after tx_active falls.
- tx_dv is exactly one cycle wide. tx_byte is stable from tx_dv until tx_done.
- Simultaneous events:
  - Pending freed on the same cycle as COMMIT: the slot counts as full, so the new frame is dropped and counted as an overrun.
  - rx_dv on the same cycle the timeout reaches its limit: the byte wins and the counter clears.
- Reset mid-frame or mid-response: immediate return to the reset state. No further tx_dv is issued, even if the transmitter is mid-byte.

## Test plan
- SAMPLE_BYTES=1, mode 0, send AA 00 FA -> response AA 00 FA; frame_cnt=1.
- mode 1, CLIP_LEVEL=200, samples 199/200/201/255 on ch1 -> data bytes 199/200/200/200.
- SAMPLE_BYTES=2, mode 3, ch0 sends 0x0100 then 0x0301 -> second response data 0x0200 (bytes 00 02); the average never overflows with 0xFFFF+0xFFFF -> 0xFFFF.
- AA 05 with CHANNELS=2 -> no response, err_cnt=1; a following good frame is answered normally.
- Send AA 00, then idle TIMEOUT_CLKS+10 cycles, then a full frame -> err_cnt=1 and exactly one response.
- Hold tx_active high and send 2 complete frames -> ovr_cnt=1; after tx_active is released, only the first frame is returned.
